// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, LSB first, behind a start/done handshake.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cell_diff;
    logic               cell_bout;

    full_subtractor u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (borrow_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    res_d    = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // Result fills from the MSB so the first (LSB) bit ends up at bit 0.
                res_d    = {cell_diff, res_q[WIDTH-1:1]};
                sa_d     = {1'b0, sa_q[WIDTH-1:1]};
                sb_d     = {1'b0, sb_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    d_d     = {cell_diff, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT) || (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing D = A − B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the lab full-adder datapath. It sits behind a start/done handshake so a control FSM can launch an operation and collect the difference and final borrow.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥ 2)

Ports:
- clk  input  1  single system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on the accepting edge
- b  input  WIDTH  subtrahend, captured on the accepting edge
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse, result valid
- d  output  WIDTH  difference (A − B mod 2^WIDTH), registered
- bout  output  1  final borrow (1 iff A < B), registered

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 → load shift registers sa←a, sb←b, borrow←0, bit counter←0, result shift register cleared; go to SHIFT. start=0 → stay.
- SHIFT, each edge: cell inputs x=sa[0], y=sb[0], bin=borrow; diff = x^y^bin; bnext = (~x&y) | (~(x^y)&bin). Shift diff into result MSB (result shifts right); sa, sb shift right; borrow←bnext; counter++.
- After the WIDTH-th SHIFT edge (counter = WIDTH−1 at that edge): d←completed result, bout←bnext, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start outside IDLE is ignored, including start held high; a new operation needs start seen in IDLE.
- d and bout hold the last result until the next completion. They are not cleared by a new start.
- Reset, at any time including mid-SHIFT: state→IDLE. busy=0, done=0, d=0, bout=0. Internal shift registers, borrow, and counter are all cleared. The in-flight operation is abandoned with no done pulse.
- Arithmetic: unsigned modulo 2^WIDTH. Operands a and b are not required stable after the accepting edge.

## Timing
- Edge E0: start sampled high in IDLE. busy rises after E0.
- Edges E1..E_WIDTH: one bit processed per edge.
- After E_WIDTH: done=1, d and bout valid. After E_(WIDTH+1): done=0, busy=0, back in IDLE.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accepting edge is E_(WIDTH+2), when start is held high continuously.
- Latency start→done: WIDTH cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package serial_sub_pkg holds typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t.
- Sub-module full_subtractor is purely combinational, with ports x, y, bin, diff, bout. It is instantiated once; it is the mirror of the full adder.
- The counter width is $clog2(WIDTH) and is computed locally.

## Test plan
All scenarios use WIDTH=4.
- a=7, b=3, start pulse → done exactly 4 cycles after accepting edge, d=4, bout=0; busy high for 5 cycles.
- a=3, b=7 → d=12 (4'b1100), bout=1; a=0, b=1 → d=15, bout=1 (full borrow ripple).
- a=0, b=0 and a=15, b=15 → d=0, bout=0; d and bout hold these values across following idle cycles.
- start held high for 20 cycles with a=9, b=4 → done every 6 cycles, d=5 each time. Changing a/b while busy does not affect the in-flight result.
- reset asserted on the 2nd SHIFT edge of a=8, b=1 → no done pulse, all outputs 0 next cycle. A fresh start with a=8, b=1 then yields d=7, bout=0.
- Exhaustive sweep of all 256 a/b pairs → d == (a−b)&4'hF and bout == (a<b) for every pair.
